// File: rtl/pc_sequencer_if.sv
// Branch-decision to PC-sequencer bus: decoded branch inputs, fetch controls and the PC-stage outputs.
// master = upstream branch/decode logic, slave = pc_sequencer.
interface pc_sequencer_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              branch;
   logic [1:0]        br_kind;
   logic [ADDR_W-1:0] br_offset;
   logic [ADDR_W-1:0] br_reg;
   logic              instr_valid;
   logic              stall;
   logic              halt_req;
   logic              resume;
   logic [ADDR_W-1:0] pc;
   logic              pc_valid;
   logic              link_we;
   logic [ADDR_W-1:0] link_data;
   logic              halted;
   logic              misalign_trap;

   modport master (
      output branch, br_kind, br_offset, br_reg, instr_valid, stall, halt_req, resume,
      input  pc, pc_valid, link_we, link_data, halted, misalign_trap
   );

   modport slave (
      input  branch, br_kind, br_offset, br_reg, instr_valid, stall, halt_req, resume,
      output pc, pc_valid, link_we, link_data, halted, misalign_trap
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter stage: owns the architectural PC and selects sequential, relative, register or call targets.
// Handles stall, halt/resume and sticky misaligned-target trapping; all outputs are registered.
module pc_sequencer #(
   parameter int unsigned              ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]        RESET_PC = '0,
   parameter int unsigned              STEP     = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   pc_sequencer_if.slave      bus
);

   localparam logic [1:0] KIND_NONE = 2'b00;
   localparam logic [1:0] KIND_REL  = 2'b01;
   localparam logic [1:0] KIND_REG  = 2'b10;
   localparam logic [1:0] KIND_CALL = 2'b11;

   typedef enum logic [2:0] {
      BOOT  = 3'd0,
      RUN   = 3'd1,
      STALL = 3'd2,
      HALT  = 3'd3,
      TRAP  = 3'd4
   } state_t;

   state_t            state;
   logic              halt_pend;

   logic [ADDR_W-1:0] seq_pc;
   logic [ADDR_W-1:0] rel_pc;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] next_pc;
   logic              taken;
   logic              is_call;
   logic              misaligned;
   logic              halt_now;

   // Next-PC selection; all sums wrap modulo 2^ADDR_W.
   always_comb begin
      seq_pc     = bus.pc + ADDR_W'(STEP);
      rel_pc     = bus.pc + bus.br_offset;
      taken      = bus.instr_valid && bus.branch && (bus.br_kind != KIND_NONE);
      is_call    = (bus.br_kind == KIND_CALL);
      target     = seq_pc;
      case (bus.br_kind)
         KIND_REL:  target = rel_pc;
         KIND_REG:  target = bus.br_reg;
         KIND_CALL: target = rel_pc;
         default:   target = seq_pc;
      endcase
      misaligned = taken && (target[1:0] != 2'b00);
      next_pc    = taken ? target : seq_pc;
      halt_now   = bus.halt_req || halt_pend;
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= BOOT;
         halt_pend         <= 1'b0;
         bus.pc            <= RESET_PC;
         bus.pc_valid      <= 1'b0;
         bus.link_we       <= 1'b0;
         bus.link_data     <= '0;
         bus.halted        <= 1'b0;
         bus.misalign_trap <= 1'b0;
      end else begin
         bus.link_we <= 1'b0;
         case (state)
            BOOT: begin
               state        <= RUN;
               bus.pc_valid <= 1'b1;
            end

            RUN: begin
               if (bus.stall) begin
                  // Stall wins over a coincident halt; the halt is remembered for later.
                  state <= STALL;
                  if (bus.halt_req) begin
                     halt_pend <= 1'b1;
                  end
               end else if (misaligned) begin
                  state             <= TRAP;
                  halt_pend         <= 1'b0;
                  bus.pc_valid      <= 1'b0;
                  bus.misalign_trap <= 1'b1;
               end else begin
                  bus.pc <= next_pc;
                  if (taken && is_call) begin
                     bus.link_we   <= 1'b1;
                     bus.link_data <= seq_pc;
                  end
                  if (halt_now) begin
                     state        <= HALT;
                     halt_pend    <= 1'b0;
                     bus.pc_valid <= 1'b0;
                     bus.halted   <= 1'b1;
                  end
               end
            end

            STALL: begin
               if (bus.halt_req) begin
                  halt_pend <= 1'b1;
               end
               if (!bus.stall) begin
                  state <= RUN;
               end
            end

            HALT: begin
               // A coincident halt_req keeps the sequencer halted.
               if (bus.resume && !bus.halt_req) begin
                  state        <= RUN;
                  bus.pc_valid <= 1'b1;
                  bus.halted   <= 1'b0;
               end
            end

            TRAP: begin
               bus.pc_valid <= 1'b0;
            end

            default: begin
               state        <= BOOT;
               bus.pc_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hand-computed PC, link, halt and trap expectations.
module tb_pc_sequencer;

   localparam int unsigned ADDR_W = 32;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   pc_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

   pc_sequencer #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (32'h0000_0000),
      .STEP     (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic br, input logic [1:0] kind, input logic [31:0] off, input logic [31:0] rg);
      bus.branch    = br;
      bus.br_kind   = kind;
      bus.br_offset = off;
      bus.br_reg    = rg;
   endtask

   initial begin
      n_checks        = 0;
      n_errors        = 0;
      rst_n           = 1'b0;
      bus.instr_valid = 1'b0;
      bus.stall       = 1'b0;
      bus.halt_req    = 1'b0;
      bus.resume      = 1'b0;
      drive(1'b0, 2'b00, 32'h0, 32'h0);

      // Reset state
      tick();
      tick();
      check("rst_pc",        bus.pc,            32'h0);
      check("rst_pc_valid",  bus.pc_valid,      32'h0);
      check("rst_link_we",   bus.link_we,       32'h0);
      check("rst_link_data", bus.link_data,     32'h0);
      check("rst_halted",    bus.halted,        32'h0);
      check("rst_trap",      bus.misalign_trap, 32'h0);

      // BOOT cycle then sequential fetch
      rst_n = 1'b1;
      bus.instr_valid = 1'b1;
      check("boot_pc_valid", bus.pc_valid, 32'h0);
      tick();
      check("run_pc_valid", bus.pc_valid, 32'h1);
      check("seq_pc0", bus.pc, 32'h0);
      tick(); check("seq_pc4",  bus.pc, 32'h4);
      tick(); check("seq_pc8",  bus.pc, 32'h8);
      tick(); check("seq_pc12", bus.pc, 32'hC);

      // branch with kind 00 is sequential
      drive(1'b1, 2'b00, 32'h40, 32'h0);
      tick(); check("kind00_ignored", bus.pc, 32'h10);

      // Relative with negative offset, then register target
      drive(1'b1, 2'b10, 32'h0, 32'h100);
      tick(); check("reg_0x100", bus.pc, 32'h100);
      drive(1'b1, 2'b01, 32'hFFFF_FFF0, 32'h0);
      tick(); check("rel_neg", bus.pc, 32'hF0);
      drive(1'b1, 2'b10, 32'h0, 32'h2000);
      tick(); check("reg_0x2000", bus.pc, 32'h2000);

      // Call with link
      drive(1'b1, 2'b10, 32'h0, 32'h40);
      tick(); check("reg_0x40", bus.pc, 32'h40);
      check("no_link_on_reg", bus.link_we, 32'h0);
      drive(1'b1, 2'b11, 32'h20, 32'h0);
      tick();
      check("call_pc",        bus.pc,        32'h60);
      check("call_link_we",   bus.link_we,   32'h1);
      check("call_link_data", bus.link_data, 32'h44);
      drive(1'b0, 2'b00, 32'h0, 32'h0);
      tick();
      check("after_call_pc",        bus.pc,        32'h64);
      check("after_call_link_we",   bus.link_we,   32'h0);
      check("after_call_link_data", bus.link_data, 32'h44);

      // Stall holds pc and ignores branch inputs
      drive(1'b1, 2'b10, 32'h0, 32'h10);
      tick(); check("reg_0x10", bus.pc, 32'h10);
      bus.stall = 1'b1;
      drive(1'b1, 2'b01, 32'h8, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_pc_hold",  bus.pc,       32'h10);
         check("stall_pc_valid", bus.pc_valid, 32'h1);
         check("stall_link_we",  bus.link_we,  32'h0);
      end
      bus.stall = 1'b0;
      tick(); check("stall_exit_pc", bus.pc, 32'h10);
      tick(); check("re_presented",  bus.pc, 32'h18);

      // Stall and halt together: halt only after stall clears
      drive(1'b0, 2'b00, 32'h0, 32'h0);
      bus.stall    = 1'b1;
      bus.halt_req = 1'b1;
      tick();
      check("sh_pc",     bus.pc,     32'h18);
      check("sh_halted", bus.halted, 32'h0);
      bus.halt_req = 1'b0;
      tick(); check("sh_still_stalled", bus.halted, 32'h0);
      bus.stall = 1'b0;
      tick();
      check("sh_exit_halted", bus.halted, 32'h0);
      check("sh_exit_pc",     bus.pc,     32'h18);
      tick();
      check("halt_pc",       bus.pc,       32'h1C);
      check("halt_halted",   bus.halted,   32'h1);
      check("halt_pc_valid", bus.pc_valid, 32'h0);
      tick(); check("halt_hold_pc", bus.pc, 32'h1C);
      bus.halt_req = 1'b1;
      bus.resume   = 1'b1;
      tick(); check("halt_beats_resume", bus.halted, 32'h1);
      bus.halt_req = 1'b0;
      tick();
      check("resume_halted",   bus.halted,   32'h0);
      check("resume_pc_valid", bus.pc_valid, 32'h1);
      check("resume_pc",       bus.pc,       32'h1C);
      bus.resume = 1'b0;
      tick(); check("resume_advance", bus.pc, 32'h20);

      // Misaligned target traps
      drive(1'b1, 2'b10, 32'h0, 32'h80);
      tick(); check("reg_0x80", bus.pc, 32'h80);
      drive(1'b1, 2'b01, 32'h6, 32'h0);
      tick();
      check("trap_set",      bus.misalign_trap, 32'h1);
      check("trap_pc",       bus.pc,            32'h80);
      check("trap_pc_valid", bus.pc_valid,      32'h0);
      check("trap_link_we",  bus.link_we,       32'h0);
      drive(1'b1, 2'b11, 32'h10, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("trap_sticky",    bus.misalign_trap, 32'h1);
         check("trap_hold_pc",   bus.pc,            32'h80);
         check("trap_no_link",   bus.link_we,       32'h0);
      end

      // Asynchronous reset mid-trap
      #2 rst_n = 1'b0;
      #1;
      check("arst_trap_clear", bus.misalign_trap, 32'h0);
      check("arst_pc",         bus.pc,            32'h0);
      tick();
      rst_n = 1'b1;
      drive(1'b0, 2'b00, 32'h0, 32'h0);
      tick(); check("reboot_pc", bus.pc, 32'h0);

      // Wrap-around
      drive(1'b1, 2'b10, 32'h0, 32'hFFFF_FFFC);
      tick(); check("reg_top", bus.pc, 32'hFFFF_FFFC);
      drive(1'b0, 2'b00, 32'h0, 32'h0);
      tick(); check("wrap", bus.pc, 32'h0);

      // Asynchronous reset mid-HALT
      bus.halt_req = 1'b1;
      tick();
      check("halt2_halted", bus.halted, 32'h1);
      check("halt2_pc",     bus.pc,     32'h4);
      bus.halt_req = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("arst_halt_pc",       bus.pc,       32'h0);
      check("arst_halt_halted",   bus.halted,   32'h0);
      check("arst_halt_pc_valid", bus.pc_valid, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage directly downstream of the branch-decision logic.
- Consumes the one-bit branch-taken decision plus the decoded target information and owns the architectural PC.
- Each cycle it selects sequential fetch (PC+4), a PC-relative target, a register target, or a call with return-address link.
- Supports fetch stall, halt, resume and misaligned-target trapping; drives the instruction-memory address.

Parameters:
ADDR_W, 32, width of PC, offsets and register targets
RESET_PC, 0, PC value loaded on reset
STEP, 4, byte increment for sequential fetch

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
branch  in  1  branch-taken decision from the branch-decision stage, valid while instr_valid=1
br_kind  in  2  00 none, 01 PC-relative, 10 register-absolute, 11 call (PC-relative with link)
br_offset  in  ADDR_W  signed byte offset for kinds 01/11
br_reg  in  ADDR_W  target address for kind 10
instr_valid  in  1  current instruction's decode/branch inputs are valid
stall  in  1  hold PC (memory or hazard stall)
halt_req  in  1  enter HALT after the current instruction retires
resume  in  1  leave HALT
pc  out  ADDR_W  current fetch address
pc_valid  out  1  pc is a valid fetch request this cycle
link_we  out  1  one-cycle pulse: write link_data to return-address register
link_data  out  ADDR_W  return address (PC+STEP of the call)
halted  out  1  high while in HALT
misalign_trap  out  1  sticky; set when a taken target has addr[1:0]!=0

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_PC, pc_valid=0, link_we=0, link_data=0, halted=0, misalign_trap=0, state=BOOT.
- States: BOOT, RUN, STALL, HALT, TRAP.
- BOOT: lasts exactly one cycle after rst_n deasserts -> RUN. pc_valid=0 in BOOT and 1 in RUN/STALL.
- RUN, instr_valid=1, stall=0: next PC chosen as follows.
  - Taken only when branch=1 and br_kind!=00. branch=1 with kind 00 is ignored (sequential).
  - Kind 01: target = pc + br_offset.
  - Kind 10: target = br_reg.
  - Kind 11: target = pc + br_offset; additionally link_we=1 for one cycle with link_data = pc + STEP.
  - Not taken: pc + STEP.
  - All sums are modulo 2^ADDR_W (wrap, no overflow flag).
- RUN, instr_valid=0, stall=0: pc advances by STEP.
- Misaligned target: a taken target with target[1:0]!=0 sets misalign_trap=1, does not update pc, suppresses link_we, and moves to TRAP. TRAP holds pc, pc_valid=0, and is left only by reset.
- stall=1 in RUN -> STALL. PC holds and branch inputs are ignored; link_we is never asserted while stalled. stall=0 -> RUN next cycle. The branch is not lost: upstream re-presents it with instr_valid.
- halt_req=1 in RUN: the current cycle's PC update completes, including any branch/link; then HALT. In HALT: pc holds, pc_valid=0, halted=1.
- halt_req during STALL is deferred until the stall clears.
- resume=1 in HALT -> RUN next cycle with the same pc. resume is ignored outside HALT.
- Simultaneous stall=1 and halt_req=1 in RUN: stall wins, halt is taken later.
- Simultaneous halt_req and resume: halt_req wins.
- Latency: a taken-branch decision in cycle N appears on pc in cycle N+1. link_we pulses in cycle N+1 alongside the new pc.
- Reset asserted mid-operation returns to BOOT regardless of state; misalign_trap clears only on reset.

Test Plan:
- Reset release with RESET_PC=0 -> one cycle pc_valid=0, then pc 0,4,8,12 on successive cycles with instr_valid=1, branch=0.
- pc=0x100, branch=1, kind=01, offset=0xFFFFFFF0 -> next pc=0x0F0. Then kind=10, br_reg=0x2000 -> pc=0x2000.
- pc=0x40, branch=1, kind=11, offset=0x20 -> pc=0x60, link_we=1 for one cycle with link_data=0x44.
- pc=0x80, branch=1, kind=01, offset=0x6 -> misalign_trap=1, pc stays 0x80, pc_valid=0, link_we=0; persists until rst_n low.
- pc=0x10: stall for 3 cycles with branch=1 present -> pc holds 0x10. After stall drops, the re-presented kind=01 offset=0x8 gives pc=0x18. Also assert stall and halt_req together -> halts only after the stall ends; resume -> pc unchanged, pc_valid=1.
- pc=0xFFFFFFFC, sequential fetch -> pc wraps to 0x00000000. Pulse rst_n low mid-HALT -> pc=RESET_PC, halted=0 immediately (asynchronous).
